// File: rtl/decrypt_pkg.sv
// Shared decryption helpers: widths, default FIFO depth, nibble permutation and byte decode.
// expand_nibble is the single definition of the permutation used by encryptor and decryptor.
package decrypt_pkg;

  localparam int NIBBLE_W           = 4;
  localparam int BYTE_W             = 8;
  localparam int FIFO_DEPTH_DEFAULT = 4;

  function automatic logic [BYTE_W-1:0] expand_nibble(input logic [NIBBLE_W-1:0] p);
    return {p[3], p[0], p[1], p[2], p[1], p[3], p[2], p[0]};
  endfunction

  // The low nibble travels in clear; the high nibble is masked by a key-dependent 4-bit sum.
  function automatic logic [BYTE_W-1:0] decode_byte(input logic [BYTE_W-1:0] cipher,
                                                    input logic [BYTE_W-1:0] key);
    logic [NIBBLE_W-1:0] p_lo;
    logic [BYTE_W-1:0]   x;
    logic [NIBBLE_W-1:0] s;
    p_lo = cipher[3:0];
    x    = expand_nibble(p_lo) ^ key;
    s    = x[7:4] + x[3:0] + {3'b000, key[0]};
    return {cipher[7:4] ^ s, p_lo};
  endfunction

endpackage

// File: rtl/decrypt_stream_byte_fifo.sv
// byte_fifo: power-of-two depth, 8-bit data; pointers wrap naturally, pop on empty is ignored.
module byte_fifo
  import decrypt_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [BYTE_W-1:0]          wr_data,
  output logic [BYTE_W-1:0]          rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/decrypt_stream.sv
// decrypt_stream: ciphertext in, key-tagged decode stage, plaintext out through byte_fifo.
// Optional DECRYPT_COUNT_EN adds the byte_count delivery counter port.
//
// state | meaning
// NOKEY | no key loaded since reset; input blocked
// RUN   | key present; accepting bytes (left only by reset)
module decrypt_stream
  import decrypt_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              key_load,
  input  logic [BYTE_W-1:0] key_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BYTE_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BYTE_W-1:0] out_data,
  output logic              key_ok
`ifdef DECRYPT_COUNT_EN
  ,
  output logic [15:0]       byte_count
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic {NOKEY, RUN} state_t;

  state_t            state;
  logic [BYTE_W-1:0] key_reg;
  logic              s1_valid;
  logic [BYTE_W-1:0] s1_data;
  logic [BYTE_W-1:0] s1_key;
  logic [CW-1:0]     fifo_count;
  logic [CW-1:0]     occupancy;
  logic              fifo_full;
  logic              fifo_empty;
  logic              accept;
  logic              pop;

  // Conservative: a same-cycle pop earns no credit.
  assign occupancy = fifo_count + CW'(s1_valid);
  assign in_ready  = key_ok && !fifo_full && (occupancy < CW'(FIFO_DEPTH));
  assign accept    = in_valid && in_ready;
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= NOKEY;
      key_ok  <= 1'b0;
      key_reg <= '0;
    end else begin
      if (key_load) key_reg <= key_in;
      case (state)
        NOKEY: if (key_load) begin
          state  <= RUN;
          key_ok <= 1'b1;
        end
        RUN:     state <= RUN;
        default: state <= NOKEY;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) s1_valid <= 1'b0;
    else       s1_valid <= accept;
  end

  // Snapshot takes the pre-edge key, so a same-edge key_load applies to the next byte.
  always_ff @(posedge clock) begin
    if (accept) begin
      s1_data <= in_data;
      s1_key  <= key_reg;
    end
  end

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (s1_valid),
    .pop     (pop),
    .wr_data (decode_byte(s1_data, s1_key)),
    .rd_data (out_data),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

`ifdef DECRYPT_COUNT_EN
  always_ff @(posedge clock) begin
    if (reset)    byte_count <= '0;
    else if (pop) byte_count <= byte_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_decrypt_stream.sv
// Randomised and directed bench for decrypt_stream against a queue-based reference model.
// Honours DECRYPT_COUNT_EN for the byte_count port and its wrap scenario.
module tb_decrypt_stream;

  localparam int DEPTH = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       key_load;
  logic [7:0] key_in;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       key_ok;
`ifdef DECRYPT_COUNT_EN
  logic [15:0] byte_count;
`endif

  always #5 clock = ~clock;

  decrypt_stream #(.FIFO_DEPTH(DEPTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .key_load   (key_load),
    .key_in     (key_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .key_ok     (key_ok)
`ifdef DECRYPT_COUNT_EN
    ,
    .byte_count (byte_count)
`endif
  );

  int total = 0;
  int bad   = 0;

  // reference model state
  bit         m_key_ok;
  logic [7:0] m_key;
  logic [7:0] m_flight[$];
  logic [7:0] m_fifo[$];
  int         m_cnt;
  int         n_acc;
  int         n_pop;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_decode(input logic [7:0] c, input logic [7:0] k);
    logic [3:0] p;
    logic [7:0] e;
    logic [7:0] x;
    int         s;
    p = c[3:0];
    e = {p[3], p[0], p[1], p[2], p[1], p[3], p[2], p[0]};
    x = e ^ k;
    s = (int'(x[7:4]) + int'(x[3:0]) + int'(k[0])) % 16;
    return {c[7:4] ^ 4'(s), p};
  endfunction

  function automatic bit m_in_ready();
    return m_key_ok && (m_fifo.size() + m_flight.size() < DEPTH);
  endfunction

  // Called at a negedge: check outputs, drive inputs, advance one edge, return at next negedge.
  task automatic cycle(input bit kl, input logic [7:0] ki, input bit iv,
                       input logic [7:0] id, input bit ordy);
    bit rdy;
    key_load = kl; key_in = ki; in_valid = iv; in_data = id; out_ready = ordy;
    rdy = m_in_ready();
    check("in_ready", in_ready, rdy);
    check("key_ok", key_ok, m_key_ok);
    check("out_valid", out_valid, m_fifo.size() != 0);
    if (m_fifo.size() != 0) check("out_data", out_data, m_fifo[0]);
`ifdef DECRYPT_COUNT_EN
    check("byte_count", byte_count, m_cnt);
`endif
    @(posedge clock);
    if (ordy && m_fifo.size() != 0) begin
      void'(m_fifo.pop_front());
      m_cnt = (m_cnt + 1) % 65536;
      n_pop++;
    end
    while (m_flight.size() != 0) m_fifo.push_back(m_flight.pop_front());
    if (iv && rdy) begin
      m_flight.push_back(ref_decode(id, m_key));
      n_acc++;
    end
    if (kl) begin
      m_key    = ki;
      m_key_ok = 1'b1;
    end
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    key_load = 0; key_in = 0; in_valid = 1; in_data = 8'h5A; out_ready = 0;
    @(posedge clock);
    m_key_ok = 0; m_key = 0; m_flight.delete(); m_fifo.delete(); m_cnt = 0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1; key_load = 0; key_in = 0; in_valid = 0; in_data = 0; out_ready = 0;
    @(negedge clock);
    do_reset();

    // no key: input must stay blocked
    for (int i = 0; i < 5; i++) cycle(0, 8'h00, 1, 8'($urandom), 1);

    // single byte, key 0x93
    cycle(1, 8'h93, 0, 8'h00, 0);
    cycle(0, 8'h00, 1, 8'h06, 0);
    check("lat_edge1_valid", out_valid, 0);
    cycle(0, 8'h00, 0, 8'h00, 0);
    check("lat_edge2_valid", out_valid, 1);
    check("first_byte", out_data, 8'h46);
    cycle(0, 8'h00, 0, 8'h00, 1);

    // key change on the same edge a byte is accepted
    cycle(1, 8'hAC, 1, 8'h06, 0);
    cycle(0, 8'h00, 1, 8'h39, 0);
    cycle(0, 8'h00, 0, 8'h00, 0);
    check("old_key_byte", out_data, 8'h46);
    cycle(0, 8'h00, 0, 8'h00, 1);
    check("new_key_byte", out_data, 8'hC9);
    cycle(0, 8'h00, 0, 8'h00, 1);

    // backpressure: only DEPTH bytes get in, then drain all
    n_acc = 0;
    for (int i = 0; i < 8; i++) cycle(0, 8'h00, 1, 8'($urandom), 0);
    check("full_accepts", n_acc, DEPTH);
    check("full_in_ready", in_ready, 0);
    n_pop = 0;
    for (int i = 0; i < 8; i++) cycle(0, 8'h00, 0, 8'h00, 1);
    check("drain_pops", n_pop, DEPTH);
    check("drain_empty", out_valid, 0);

    // random traffic with occasional key changes
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(15) == 0, 8'($urandom), $urandom_range(9) < 7,
            8'($urandom), $urandom_range(9) < 6);
    for (int i = 0; i < 8; i++) cycle(0, 8'h00, 0, 8'h00, 1);

    // reset with 3 bytes buffered
    n_acc = 0;
    for (int i = 0; i < 3; i++) cycle(0, 8'h00, 1, 8'($urandom), 0);
    cycle(0, 8'h00, 0, 8'h00, 0);
    check("pre_reset_acc", n_acc, 3);
    do_reset();
    check("rst_out_valid", out_valid, 0);
    check("rst_key_ok", key_ok, 0);
    check("rst_in_ready", in_ready, 0);
    cycle(1, 8'h93, 0, 8'h00, 0);
    cycle(0, 8'h00, 1, 8'h06, 0);
    cycle(0, 8'h00, 0, 8'h00, 0);
    check("fresh_after_reset", out_data, 8'h46);
    for (int i = 0; i < 3; i++) cycle(0, 8'h00, 0, 8'h00, 1);
    check("fresh_only", out_valid, 0);

`ifdef DECRYPT_COUNT_EN
    do_reset();
    cycle(1, 8'h11, 0, 8'h00, 1);
    for (int i = 0; i < 70000 && m_cnt != 65535; i++) cycle(0, 8'h00, 1, 8'($urandom), 1);
    check("count_ffff", byte_count, 16'hFFFF);
    for (int i = 0; i < 4 && m_cnt != 0; i++) cycle(0, 8'h00, 0, 8'h00, 1);
    check("count_wrap", byte_count, 16'h0000);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
